// File: rtl/typedef_pkg.sv
// Shared fetch-path types: instruction slot, predictor record and fetch FSM state.
package typedef_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic            valid;
  } fetch_t;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } predict_t;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_FETCH,
    FS_HALT
  } fetch_state_e;

  function automatic logic [1:0] num_valid(input fetch_t a, input fetch_t b);
    return {1'b0, a.valid} + {1'b0, b.valid};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: 2-wide in-order enqueue and dequeue, flush, occupancy count.
module fetch_queue
  import typedef_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       enq_en_i,
  input  fetch_t                     enq_0_i,
  input  fetch_t                     enq_1_i,
  input  logic [1:0]                 deq_cnt_i,
  output fetch_t                     head_0_o,
  output fetch_t                     head_1_o,
  output logic [$clog2(FQ_DEPTH):0]  count_o
);

  localparam int unsigned PtrW = $clog2(FQ_DEPTH);

  fetch_t          mem_q [FQ_DEPTH];
  logic [PtrW-1:0] head_q, tail_q, tail_1;
  logic [PtrW:0]   count_q;
  logic [1:0]      enq_n;

  always_comb begin
    enq_n = 2'd0;
    if (enq_en_i) enq_n = num_valid(enq_0_i, enq_1_i);
  end

  // Slot 1 lands right behind slot 0 only when slot 0 was actually written.
  assign tail_1 = tail_q + PtrW'(enq_0_i.valid);

  always_comb begin
    head_0_o = '0;
    head_1_o = '0;
    if (count_q != '0) head_0_o = mem_q[head_q];
    if (count_q > (PtrW+1)'(1)) head_1_o = mem_q[head_q + PtrW'(1)];
  end

  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < FQ_DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      head_q  <= tail_q;
      count_q <= '0;
    end else begin
      if (enq_en_i && enq_0_i.valid) mem_q[tail_q] <= enq_0_i;
      if (enq_en_i && enq_1_i.valid) mem_q[tail_1] <= enq_1_i;
      tail_q  <= tail_q + PtrW'(enq_n);
      head_q  <= head_q + PtrW'(deq_cnt_i);
      count_q <= count_q + (PtrW+1)'(enq_n) - (PtrW+1)'(deq_cnt_i);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, drives the ROM, fills the fetch queue, feeds decode.
// Optional FETCH_PERF_CNT_EN adds saturating stall-cycle and redirect counters.
module fetch_sequencer
  import typedef_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned            FQ_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  fetch_t                rom_instr_0,
  input  fetch_t                rom_instr_1,
  input  logic [ADDR_WIDTH-1:0] pred_next_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  dec_ready,
  output fetch_t                dec_instr_0,
  output fetch_t                dec_instr_1,
  output logic                  fetch_stall
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_redirects
`endif
);

  localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CntW-1:0]       fq_count, free_cnt;
  logic                  fire;
  fetch_t                enq_1;
  logic [1:0]            deq_cnt;

  assign free_cnt = CntW'(FQ_DEPTH) - fq_count;

  // Stall is judged on the registered count; a same-cycle dequeue helps only next cycle.
  assign fire        = (state_q == FS_FETCH) && (free_cnt >= CntW'(2)) && !redirect_valid;
  assign fetch_stall = (state_q != FS_FETCH) || (free_cnt < CntW'(2));
  assign rom_addr    = pc_q;

  always_comb begin
    enq_1       = rom_instr_1;
    enq_1.valid = rom_instr_0.valid & rom_instr_1.valid;
  end

  always_comb begin
    deq_cnt = 2'd0;
    if (dec_ready && !redirect_valid) deq_cnt = num_valid(dec_instr_0, dec_instr_1);
  end

  fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (redirect_valid),
    .enq_en_i  (fire),
    .enq_0_i   (rom_instr_0),
    .enq_1_i   (enq_1),
    .deq_cnt_i (deq_cnt),
    .head_0_o  (dec_instr_0),
    .head_1_o  (dec_instr_1),
    .count_o   (fq_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
    end else if (redirect_valid) begin
      state_q <= FS_FETCH;
      pc_q    <= redirect_pc;
    end else begin
      case (state_q)
        FS_IDLE:  state_q <= FS_FETCH;
        FS_FETCH: begin
          if (fire) begin
            // A missing slot means we ran off the end of the ROM.
            if (rom_instr_0.valid && rom_instr_1.valid) pc_q <= pred_next_pc;
            else                                       state_q <= FS_HALT;
          end
        end
        FS_HALT:  state_q <= FS_HALT;
        default:  state_q <= FS_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_redir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
    end else begin
      if (fetch_stall && (state_q != FS_IDLE) && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_valid && (perf_redir_q != '1))
        perf_redir_q <= perf_redir_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redir_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; decode-side scoreboard checks every consumed slot.
module tb_fetch_sequencer;
  import typedef_pkg::*;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, dec_ready;
  logic [31:0] rom_addr, pred_next_pc, redirect_pc;
  fetch_t      rom_instr_0, rom_instr_1, dec_instr_0, dec_instr_1;
  logic        fetch_stall;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_redirects;
`endif

  int total = 0;
  int bad   = 0;
  fetch_t sb[$];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_instr_0    (rom_instr_0),
    .rom_instr_1    (rom_instr_1),
    .pred_next_pc   (pred_next_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .dec_instr_0    (dec_instr_0),
    .dec_instr_1    (dec_instr_1),
    .fetch_stall    (fetch_stall)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
`endif
  );

  // 4 KiB ROM model; slot 1 sits 4 bytes after slot 0, predictor falls through by 8.
  function automatic fetch_t rom_word(input logic [31:0] a);
    fetch_t f;
    f.addr  = a;
    f.data  = {a[15:0], ~a[15:0]};
    f.valid = (a < 32'd4096);
    return f;
  endfunction

  always_comb begin
    rom_instr_0 = rom_word(rom_addr);
    rom_instr_1 = rom_word(rom_addr + 32'd4);
  end
  assign pred_next_pc = rom_addr + 32'd8;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic chk_fe(input string name, input fetch_t got, input fetch_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    sb.push_back(rom_word(a));
  endtask

  task automatic pop_cmp(input string name, input fetch_t got);
    fetch_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %h want nothing (scoreboard empty)", name, got);
    end else begin
      e = sb.pop_front();
      chk_fe(name, got, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: compares every slot decode actually takes against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && dec_ready && !redirect_valid) begin
        if (dec_instr_0.valid) pop_cmp("dec0_pop", dec_instr_0);
        if (dec_instr_1.valid) pop_cmp("dec1_pop", dec_instr_1);
      end
    end
  end

  initial begin
    rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    mid();
    chk("rst_rom_addr", rom_addr, 32'h0);
    chk("rst_stall", {31'b0, fetch_stall}, 32'd1);
    chk_fe("rst_dec0", dec_instr_0, '0);
    chk_fe("rst_dec1", dec_instr_1, '0);

    tick(); rst = 1'b0;                       // C0: IDLE
    mid();
    chk("idle_rom_addr", rom_addr, 32'h0);
    chk("idle_stall", {31'b0, fetch_stall}, 32'd1);
    tick(); mid();                            // C1: first fetch
    chk("c1_rom_addr", rom_addr, 32'h0);
    chk("c1_stall", {31'b0, fetch_stall}, 32'd0);
    tick(); mid();                            // C2
    chk("c2_rom_addr", rom_addr, 32'h8);
    chk_fe("c2_dec0", dec_instr_0, rom_word(32'h0));
    chk_fe("c2_dec1", dec_instr_1, rom_word(32'h4));
    tick(); mid();                            // C3
    chk("c3_rom_addr", rom_addr, 32'h10);
    tick(); mid();                            // C4
    chk("c4_rom_addr", rom_addr, 32'h18);
    chk("c4_stall", {31'b0, fetch_stall}, 32'd0);
    tick(); mid();                            // C5: queue full
    chk("full_stall", {31'b0, fetch_stall}, 32'd1);
    chk("full_rom_addr", rom_addr, 32'h20);
    tick(); mid();                            // C6
    chk("full_stall2", {31'b0, fetch_stall}, 32'd1);
    chk("full_rom_frozen", rom_addr, 32'h20);
    tick(); dec_ready = 1'b1; push_exp(32'h0); push_exp(32'h4);
    mid();                                    // C7: dequeue, still stalled
    chk("deq_same_cycle_stall", {31'b0, fetch_stall}, 32'd1);
    tick(); dec_ready = 1'b0;
    mid();                                    // C8: fetch resumes
    chk("resume_stall", {31'b0, fetch_stall}, 32'd0);
    chk("resume_rom_addr", rom_addr, 32'h20);
    tick(); dec_ready = 1'b1; push_exp(32'h8); push_exp(32'hC);
    mid();                                    // C9
    chk("c9_stall", {31'b0, fetch_stall}, 32'd1);
    chk("c9_rom_addr", rom_addr, 32'h28);
    tick(); dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    mid();                                    // C10: redirect with 6 entries
    tick(); redirect_valid = 1'b0;
    mid();                                    // C11
    chk("flush_dec0_valid", {31'b0, dec_instr_0.valid}, 32'd0);
    chk("flush_dec1_valid", {31'b0, dec_instr_1.valid}, 32'd0);
    chk("redir_rom_addr", rom_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_redir_1", perf_redirects, 32'd1);
    chk("perf_stall_4", perf_stall_cycles, 32'd4);
`endif
    tick(); mid();                            // C12
    chk_fe("redir_dec0", dec_instr_0, rom_word(32'h100));
    tick(); mid();                            // C13
    tick(); dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(32'h100 + 32'(4 * i));
    mid();                                    // C14: deq 2 + enq 2 at count 6, wraps 7->0
    tick(); mid();                            // C15
    chk("steady_stall", {31'b0, fetch_stall}, 32'd0);
    tick(); mid();                            // C16
    tick(); mid();                            // C17
    chk("steady_stall2", {31'b0, fetch_stall}, 32'd0);
    chk("steady_rom_addr", rom_addr, 32'h130);
    tick(); dec_ready = 1'b0;
    mid();                                    // C18
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFF4;
    mid();                                    // C19
    chk("c19_stall", {31'b0, fetch_stall}, 32'd1);
    tick(); redirect_valid = 1'b0;
    mid();                                    // C20
    chk("c20_rom_addr", rom_addr, 32'hFF4);
    tick(); mid();                            // C21: last word, slot 1 out of range
    chk("end_rom_addr", rom_addr, 32'hFFC);
    chk("end_stall", {31'b0, fetch_stall}, 32'd0);
    tick(); dec_ready = 1'b1; push_exp(32'hFF4); push_exp(32'hFF8); push_exp(32'hFFC);
    mid();                                    // C22: HALT
    chk("halt_stall", {31'b0, fetch_stall}, 32'd1);
    chk("halt_rom_addr", rom_addr, 32'hFFC);
    tick(); mid();                            // C23
    chk("halt_stall2", {31'b0, fetch_stall}, 32'd1);
    chk_fe("halt_dec0_last", dec_instr_0, rom_word(32'hFFC));
    chk("halt_dec1_valid", {31'b0, dec_instr_1.valid}, 32'd0);
    tick(); dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    mid();                                    // C24
    chk("halt_stall3", {31'b0, fetch_stall}, 32'd1);
    chk("halt_empty", {31'b0, dec_instr_0.valid}, 32'd0);
    tick(); redirect_valid = 1'b0;
    mid();                                    // C25
    chk("restart_rom_addr", rom_addr, 32'h0);
    chk("restart_stall", {31'b0, fetch_stall}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_redir_3", perf_redirects, 32'd3);
    chk("perf_stall_8", perf_stall_cycles, 32'd8);
`endif
    tick(); mid();                            // C26
    chk_fe("restart_dec0", dec_instr_0, rom_word(32'h0));
    chk_fe("restart_dec1", dec_instr_1, rom_word(32'h4));
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
